// File: rtl/bram_tree_pkg.sv
// Shared types and default sizes for the BRAM test tree.
package bram_tree_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RAM_DEPTH  = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

endpackage

// File: rtl/bram_read_checker_rd_valid_pipe.sv
// Delays a (valid, addr) pair by LATENCY cycles so read data can be matched
// to the address that produced it. Clear drops every in-flight valid bit.
module rd_valid_pipe #(
    parameter int LATENCY = 1,
    parameter int AW      = 8
) (
    input  logic          CLK,
    input  logic          clr,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    output logic          out_vld,
    output logic [AW-1:0] out_addr
);

    logic [LATENCY-1:0]         vld_pipe;
    logic [LATENCY-1:0][AW-1:0] addr_pipe;

    always_ff @(posedge CLK) begin
        if (clr) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            for (int i = 1; i < LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Addresses are meaningless without their valid bit, so they never need clearing.
    always_ff @(posedge CLK) begin
        addr_pipe[0] <= in_addr;
        for (int i = 1; i < LATENCY; i++)
            addr_pipe[i] <= addr_pipe[i-1];
    end

    assign out_vld  = vld_pipe[LATENCY-1];
    assign out_addr = addr_pipe[LATENCY-1];

endmodule

// File: rtl/bram_read_checker.sv
// Sweeps every BRAM address once per pass and checks mem[a] == base + a,
// reporting mismatch count and the first failing address/data.
module bram_read_checker
    import bram_tree_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int RAM_DEPTH    = DEF_RAM_DEPTH,
    parameter int READ_LATENCY = 1,
    localparam int AW          = $clog2(RAM_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_base,
    output logic                  o_r_en,
    output logic [AW-1:0]         o_r_addr,
    input  logic [DATA_WIDTH-1:0] i_r_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [AW:0]           o_err_count,
    output logic [AW-1:0]         o_first_err_addr,
    output logic [DATA_WIDTH-1:0] o_first_err_data
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
    localparam logic [AW:0]   ERR_MAX   = (AW+1)'(RAM_DEPTH);
    localparam logic [2:0]    DRAIN_END = 3'(READ_LATENCY - 1);

    chk_state_t            state, state_nxt;
    logic [AW-1:0]         addr;
    logic [2:0]            drain_cnt;
    logic [DATA_WIDTH-1:0] base;
    logic                  start_ok;
    logic                  cmp_vld;
    logic [AW-1:0]         cmp_addr;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic                  mismatch;

    assign start_ok = i_start && (state == IDLE || state == DONE);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = ISSUE;
            ISSUE:   if (addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_END) state_nxt = DONE;
            DONE:    if (start_ok) state_nxt = ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    rd_valid_pipe #(
        .LATENCY (READ_LATENCY),
        .AW      (AW)
    ) u_pipe (
        .CLK      (CLK),
        .clr      (RST),
        .in_vld   (o_r_en),
        .in_addr  (o_r_addr),
        .out_vld  (cmp_vld),
        .out_addr (cmp_addr)
    );

    // Expected pattern wraps modulo 2^DATA_WIDTH by plain truncation.
    assign cmp_exp  = base + DATA_WIDTH'(cmp_addr);
    assign mismatch = cmp_vld && (i_r_data != cmp_exp);

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr             <= '0;
            drain_cnt        <= '0;
            base             <= '0;
            o_err_count      <= '0;
            o_first_err_addr <= '0;
            o_first_err_data <= '0;
        end else if (start_ok) begin
            addr             <= '0;
            drain_cnt        <= '0;
            base             <= i_base;
            o_err_count      <= '0;
            o_first_err_addr <= '0;
            o_first_err_data <= '0;
        end else begin
            // Terminal count, not AW overflow, wraps the address for non-power-of-two depths.
            if (state == ISSUE)
                addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            if (state == DRAIN)
                drain_cnt <= drain_cnt + 1'b1;
            if (mismatch) begin
                if (o_err_count == '0) begin
                    o_first_err_addr <= cmp_addr;
                    o_first_err_data <= i_r_data;
                end
                if (o_err_count != ERR_MAX)
                    o_err_count <= o_err_count + 1'b1;
            end
        end
    end

    assign o_r_en   = (state == ISSUE);
    assign o_r_addr = addr;
    assign o_busy   = (state == ISSUE) || (state == DRAIN);
    assign o_done   = (state == DONE);
    assign o_pass   = o_done && (o_err_count == '0);

endmodule
